// File: rtl/iomem_pkg.sv
// iomem_pkg: shared types and constants for the iomem peripheral bus controller.
//   state_t           - controller FSM states (IDLE, ACCESS, DONE)
//   DEFAULT_BASE_PAGE - default address page of slot 0
//   TIMEOUT_RDATA     - read data returned when a slave never answers
//   UNMAPPED_RDATA    - read data returned for an unmapped page
//   page_index()      - slot index of an address page relative to the base page
package iomem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0]  DEFAULT_BASE_PAGE = 8'h03;
  localparam logic [31:0] TIMEOUT_RDATA     = 32'hFFFF_FFFF;
  localparam logic [31:0] UNMAPPED_RDATA    = 32'h0000_0000;

  // 8-bit wrap-around subtraction: pages below the base land at large indices
  // and are therefore treated as unmapped.
  function automatic logic [7:0] page_index(input logic [7:0] page, input logic [7:0] base);
    return page - base;
  endfunction

endpackage

// File: rtl/iomem_timeout.sv
// iomem_timeout: 8-bit slave-wait counter.
//   clk, resetn - clock and asynchronous active-low reset
//   clr         - restart counting from zero (request accepted)
//   en          - count this cycle (controller is waiting in ACCESS)
//   expire      - high during the LIMIT-th enabled cycle since clr
// Only instantiated when IOMEM_TIMEOUT_EN is defined.
module iomem_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // Counter holds 0 in the first wait cycle, so the LIMIT-th cycle sees LIMIT-1.
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_r;

  // Wait-cycle counter, saturating at its maximum value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= 8'h00;
    end else if (clr) begin
      cnt_r <= 8'h00;
    end else if (en && (cnt_r != 8'hFF)) begin
      cnt_r <= cnt_r + 8'h01;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en && (cnt_r == LAST);

endmodule

// File: rtl/iomem_ctrl.sv
// iomem_ctrl: routes single CPU bus requests to one of NSLV peripheral slots
// selected by address page (m_addr[31:24]); slot i owns page BASE_PAGE+i.
//   clk, resetn                 - clock, asynchronous active-low reset
//   m_valid/m_addr/m_wstrb/m_wdata - CPU request (wstrb 0 = read)
//   m_ready/m_rdata             - one-cycle completion pulse and read data
//   s_valid                     - one-hot slave request
//   s_addr/s_wstrb/s_wdata      - registered request copy, broadcast to all slots
//   s_ready/s_rdata             - per-slot ready and read data (slot i at [32i+31:32i])
//   err_pulse/err_count         - error pulse (unmapped/timeout) and saturating count
// Optional feature: define IOMEM_TIMEOUT_EN to bound the slave wait to
// TIMEOUT_CYCLES cycles; otherwise ACCESS waits for s_ready indefinitely.
module iomem_ctrl
  import iomem_pkg::*;
#(
  parameter int          NSLV           = 8,
  parameter logic [7:0]  BASE_PAGE      = DEFAULT_BASE_PAGE,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               m_valid,
  input  logic [31:0]        m_addr,
  input  logic [3:0]         m_wstrb,
  input  logic [31:0]        m_wdata,
  output logic               m_ready,
  output logic [31:0]        m_rdata,
  output logic [NSLV-1:0]    s_valid,
  output logic [31:0]        s_addr,
  output logic [3:0]         s_wstrb,
  output logic [31:0]        s_wdata,
  input  logic [NSLV-1:0]    s_ready,
  input  logic [NSLV*32-1:0] s_rdata,
  output logic               err_pulse,
  output logic [7:0]         err_count
);

  if ((NSLV < 1) || (NSLV > 256)) begin : g_bad_nslv
    $error("iomem_ctrl: NSLV must be in 1..256");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("iomem_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t            state_r;
  state_t            state_s;
  logic [NSLV-1:0]   s_valid_r;
  logic [31:0]       s_addr_r;
  logic [3:0]        s_wstrb_r;
  logic [31:0]       s_wdata_r;
  logic              m_ready_r;
  logic [31:0]       m_rdata_r;
  logic              err_pulse_r;
  logic [7:0]        err_count_r;
  logic              rearm_r;

  logic [7:0]        idx_s;
  logic              mapped_s;
  logic              accept_s;
  logic [NSLV-1:0]   onehot_s;
  logic              sel_ready_s;
  logic [31:0]       sel_rdata_s;
  logic              expire_s;
  logic [31:0]       done_rdata_s;
  logic              done_err_s;

  assign idx_s    = page_index(m_addr[31:24], BASE_PAGE);
  assign mapped_s = ({1'b0, idx_s} < 9'(NSLV));
  // A request is only taken once m_valid has been low since the last m_ready,
  // or from the second IDLE cycle onwards (see rearm_r).
  assign accept_s = (state_r == IDLE) && m_valid && rearm_r;

  // s_valid_r is one-hot on the selected slot during ACCESS, so it doubles as
  // the slot select and masks off ready/data of every other slot.
  assign sel_ready_s = |(s_ready & s_valid_r);

  // Slot decode of the incoming page and AND-OR read-data mux of the selected slot.
  always_comb begin
    onehot_s    = '0;
    sel_rdata_s = 32'h0000_0000;
    for (int i = 0; i < NSLV; i++) begin
      onehot_s[i] = (idx_s == 8'(i));
      sel_rdata_s = sel_rdata_s | (s_rdata[32*i +: 32] & {32{s_valid_r[i]}});
    end
  end

`ifdef IOMEM_TIMEOUT_EN
  iomem_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clr    (accept_s),
    .en     (state_r == ACCESS),
    .expire (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Next-state logic plus the data/error value presented in the DONE cycle.
  always_comb begin
    state_s      = state_r;
    done_rdata_s = 32'h0000_0000;
    done_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (mapped_s) begin
            state_s = ACCESS;
          end else begin
            state_s      = DONE;
            done_rdata_s = UNMAPPED_RDATA;
            done_err_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        // A ready arriving together with expiry wins: normal completion.
        if (sel_ready_s) begin
          state_s      = DONE;
          done_rdata_s = sel_rdata_s;
        end else if (expire_s) begin
          state_s      = DONE;
          done_rdata_s = TIMEOUT_RDATA;
          done_err_s   = 1'b1;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Slave-side request registers: captured on accept, s_valid held through ACCESS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_valid_r <= '0;
      s_addr_r  <= 32'h0000_0000;
      s_wstrb_r <= 4'h0;
      s_wdata_r <= 32'h0000_0000;
    end else begin
      if (state_s == ACCESS) begin
        s_valid_r <= (state_r == IDLE) ? onehot_s : s_valid_r;
      end else begin
        s_valid_r <= '0;
      end
      if (accept_s) begin
        s_addr_r  <= m_addr;
        s_wstrb_r <= m_wstrb;
        s_wdata_r <= m_wdata;
      end else begin
        s_addr_r  <= s_addr_r;
        s_wstrb_r <= s_wstrb_r;
        s_wdata_r <= s_wdata_r;
      end
    end
  end

  // CPU-side completion and error outputs, all asserted only in the DONE cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ready_r   <= 1'b0;
      m_rdata_r   <= 32'h0000_0000;
      err_pulse_r <= 1'b0;
      err_count_r <= 8'h00;
    end else begin
      m_ready_r   <= (state_s == DONE);
      m_rdata_r   <= (state_s == DONE) ? done_rdata_s : 32'h0000_0000;
      err_pulse_r <= done_err_s;
      if (done_err_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'h01;
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  // Re-arm flag: cleared on completion so a still-high m_valid is not taken as a
  // new request; set again by m_valid low or after one IDLE cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rearm_r <= 1'b1;
    end else if (state_s == DONE) begin
      rearm_r <= 1'b0;
    end else if (!m_valid || (state_r == IDLE)) begin
      rearm_r <= 1'b1;
    end else begin
      rearm_r <= rearm_r;
    end
  end

  assign m_ready   = m_ready_r;
  assign m_rdata   = m_rdata_r;
  assign s_valid   = s_valid_r;
  assign s_addr    = s_addr_r;
  assign s_wstrb   = s_wstrb_r;
  assign s_wdata   = s_wdata_r;
  assign err_pulse = err_pulse_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_iomem_ctrl.sv
// Directed testbench for iomem_ctrl. Timeout scenarios are exercised when
// IOMEM_TIMEOUT_EN is defined for the build.
module tb_iomem_ctrl;

  localparam int NSLV = 8;

  logic               clk;
  logic               resetn;
  logic               m_valid;
  logic [31:0]        m_addr;
  logic [3:0]         m_wstrb;
  logic [31:0]        m_wdata;
  logic               m_ready;
  logic [31:0]        m_rdata;
  logic [NSLV-1:0]    s_valid;
  logic [31:0]        s_addr;
  logic [3:0]         s_wstrb;
  logic [31:0]        s_wdata;
  logic [NSLV-1:0]    s_ready;
  logic [NSLV*32-1:0] s_rdata;
  logic               err_pulse;
  logic [7:0]         err_count;

  int tests_run = 0;
  int tests_failed = 0;

  iomem_ctrl #(
    .NSLV           (NSLV),
    .BASE_PAGE      (8'h03),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wstrb   (m_wstrb),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_wstrb   (s_wstrb),
    .s_wdata   (s_wdata),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
    m_valid = v;
    m_addr  = a;
    m_wstrb = ws;
    m_wdata = wd;
  endtask

  initial begin
    resetn  = 1'b0;
    s_ready = 8'h00;
    s_rdata = '0;
    set_req(1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < NSLV; i++) s_rdata[32*i +: 32] = 32'hD000_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_m_ready", 32'(m_ready), 32'h0);
    check("rst_m_rdata", m_rdata, 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_wstrb", 32'(s_wstrb), 32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_err_pulse", 32'(err_pulse), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Read slot 0, ready on first s_valid cycle; m_valid held through completion.
    s_rdata[31:0] = 32'h1234_5678;
    s_ready = 8'h01;
    set_req(1'b1, 32'h0300_0004, 4'h0, 32'h0);
    tick();
    check("rd_s_valid", 32'(s_valid), 32'h01);
    check("rd_s_addr", s_addr, 32'h0300_0004);
    check("rd_m_ready_early", 32'(m_ready), 32'h0);
    tick();
    check("rd_m_ready", 32'(m_ready), 32'h1);
    check("rd_m_rdata", m_rdata, 32'h1234_5678);
    check("rd_s_valid_drop", 32'(s_valid), 32'h0);
    check("rd_err_pulse", 32'(err_pulse), 32'h0);
    tick();
    check("rd_m_ready_1cyc", 32'(m_ready), 32'h0);
    check("rd_m_rdata_idle", m_rdata, 32'h0);
    tick();
    check("rearm_no_repeat_sv", 32'(s_valid), 32'h0);
    check("rearm_no_repeat_rdy", 32'(m_ready), 32'h0);
    m_valid = 1'b0;
    s_ready = 8'h00;
    tick();

    // Write slot 4, ready after 5 cycles; other slots' ready must be ignored.
    s_rdata[4*32 +: 32] = 32'h0000_4444;
    set_req(1'b1, 32'h0700_0000, 4'hF, 32'hA5A5_A5A5);
    s_ready = 8'hEF;
    tick();
    check("wr_s_valid_1", 32'(s_valid), 32'h10);
    check("wr_s_wdata", s_wdata, 32'hA5A5_A5A5);
    check("wr_s_wstrb", 32'(s_wstrb), 32'hF);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("wr_s_valid_%0d", k), 32'(s_valid), 32'h10);
      check($sformatf("wr_m_ready_%0d", k), 32'(m_ready), 32'h0);
    end
    s_ready = 8'h10;
    tick();
    check("wr_m_ready", 32'(m_ready), 32'h1);
    check("wr_m_rdata", m_rdata, 32'h0000_4444);
    check("wr_s_valid_drop", 32'(s_valid), 32'h0);
    m_valid = 1'b0;
    s_ready = 8'h00;
    tick();
    check("wr_single_pulse", 32'(m_ready), 32'h0);

    // Unmapped: page below base (wraps) and page just above last slot.
    set_req(1'b1, 32'h0200_0000, 4'h0, 32'h0);
    tick();
    check("um1_m_ready", 32'(m_ready), 32'h1);
    check("um1_m_rdata", m_rdata, 32'h0);
    check("um1_err_pulse", 32'(err_pulse), 32'h1);
    check("um1_s_valid", 32'(s_valid), 32'h0);
    m_valid = 1'b0;
    tick();
    check("um1_err_pulse_end", 32'(err_pulse), 32'h0);
    set_req(1'b1, 32'h0B00_0000, 4'h0, 32'h0);
    tick();
    check("um2_err_pulse", 32'(err_pulse), 32'h1);
    check("um2_m_rdata", m_rdata, 32'h0);
    check("um2_s_valid", 32'(s_valid), 32'h0);
    check("um2_err_count", 32'(err_count), 32'h2);
    m_valid = 1'b0;
    tick();
    tick();

    // Reset in the middle of ACCESS.
    set_req(1'b1, 32'h0500_0000, 4'h3, 32'h5555_0000);
    tick();
    check("ra_s_valid", 32'(s_valid), 32'h04);
    tick();
    resetn = 1'b0;
    #1;
    check("ra_s_valid_rst", 32'(s_valid), 32'h0);
    check("ra_m_ready_rst", 32'(m_ready), 32'h0);
    check("ra_s_addr_rst", s_addr, 32'h0);
    check("ra_s_wdata_rst", s_wdata, 32'h0);
    check("ra_err_count_rst", 32'(err_count), 32'h0);
    m_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("ra_no_m_ready", 32'(m_ready), 32'h0);
    check("ra_no_err", 32'(err_count), 32'h0);
    s_rdata[1*32 +: 32] = 32'h0BAD_CAFE;
    s_ready = 8'h02;
    set_req(1'b1, 32'h0400_0010, 4'h0, 32'h0);
    tick();
    check("ra_next_s_valid", 32'(s_valid), 32'h02);
    tick();
    check("ra_next_m_ready", 32'(m_ready), 32'h1);
    check("ra_next_m_rdata", m_rdata, 32'h0BAD_CAFE);
    m_valid = 1'b0;
    s_ready = 8'h00;
    tick();

`ifdef IOMEM_TIMEOUT_EN
    // Slot 2 never ready: 16 ACCESS cycles then timeout completion.
    set_req(1'b1, 32'h0500_0000, 4'h0, 32'h0);
    tick();
    for (int k = 2; k <= 16; k++) tick();
    check("to_s_valid_16", 32'(s_valid), 32'h04);
    check("to_m_ready_16", 32'(m_ready), 32'h0);
    tick();
    check("to_m_ready", 32'(m_ready), 32'h1);
    check("to_m_rdata", m_rdata, 32'hFFFF_FFFF);
    check("to_err_pulse", 32'(err_pulse), 32'h1);
    check("to_s_valid_drop", 32'(s_valid), 32'h0);
    check("to_err_count", 32'(err_count), 32'h1);
    m_valid = 1'b0;
    tick();
    // Ready on the 16th ACCESS cycle beats the timeout.
    s_rdata[2*32 +: 32] = 32'h2222_0016;
    set_req(1'b1, 32'h0500_0000, 4'h0, 32'h0);
    tick();
    for (int k = 2; k <= 16; k++) tick();
    s_ready = 8'h04;
    tick();
    check("tor_m_ready", 32'(m_ready), 32'h1);
    check("tor_m_rdata", m_rdata, 32'h2222_0016);
    check("tor_err_pulse", 32'(err_pulse), 32'h0);
    check("tor_err_count", 32'(err_count), 32'h1);
    m_valid = 1'b0;
    s_ready = 8'h00;
    tick();
`endif

    // 300 unmapped accesses saturate the error counter.
    for (int n = 0; n < 300; n++) begin
      set_req(1'b1, 32'h0B00_0000, 4'h0, 32'h0);
      tick();
      m_valid = 1'b0;
      tick();
    end
    check("sat_err_count", 32'(err_count), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/iomem_ctrl.md
IOMEM_CTRL -- requirements
Module: iomem_ctrl

Interface
REQ-001 Parameter NSLV, default 8: number of peripheral slots.
REQ-002 Parameter BASE_PAGE, default 8'h03: address page (iomem_addr[31:24]) of slot 0; slot i owns page BASE_PAGE+i.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum wait for a slave ready, range 1..255.
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 m_valid  in  1  CPU bus request.
REQ-007 m_addr  in  32  request byte address.
REQ-008 m_wstrb  in  4  byte write strobes; 0 = read.
REQ-009 m_wdata  in  32  write data.
REQ-010 m_ready  out  1  one-cycle completion pulse to CPU.
REQ-011 m_rdata  out  32  read data, valid while m_ready=1.
REQ-012 s_valid  out  NSLV  one-hot slave request.
REQ-013 s_addr / s_wstrb / s_wdata  out  32/4/32  registered copies of the request, broadcast to all slots.
REQ-014 s_ready  in  NSLV  per-slot ready.
REQ-015 s_rdata  in  NSLV*32  per-slot read data, slot i at bits [32i+31:32i].
REQ-016 err_pulse  out  1  one-cycle pulse on unmapped access or timeout.
REQ-017 err_count  out  8  saturating error count.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; IDLE after reset.
REQ-019 IDLE with m_valid=1: latch m_addr/m_wstrb/m_wdata into s_addr/s_wstrb/s_wdata; compute idx = m_addr[31:24]-BASE_PAGE in 8-bit unsigned arithmetic.
REQ-020 idx < NSLV: next state ACCESS, s_valid[idx]=1 from next cycle.
REQ-021 idx >= NSLV (includes pages below BASE_PAGE via wrap-around): next state DONE, captured rdata=0, err_pulse=1 in the DONE cycle.
REQ-022 ACCESS: s_valid stays asserted on the selected bit only; on s_ready[idx]=1 capture s_rdata slot idx, drop s_valid next cycle, go to DONE.
REQ-023 s_ready bits of non-selected slots are ignored in every state.
REQ-024 DONE: m_ready=1 and m_rdata=captured value for exactly one cycle, then IDLE; s_valid=0.
REQ-025 m_valid sampled in DONE or on the IDLE cycle directly after DONE is not treated as a new request unless it was low for at least one cycle since m_ready (re-arm flag).
REQ-026 Latency: slave ready in first s_valid cycle -> m_ready 2 cycles after m_valid; unmapped -> m_ready 1 cycle after the IDLE accept.
REQ-027 m_rdata=0 whenever m_ready=0.
REQ-028 err_count increments on each err_pulse and holds at 255.

Reset
REQ-029 resetn=0 forces, asynchronously, state=IDLE, s_valid=0, m_ready=0, m_rdata=0, s_addr/s_wstrb/s_wdata=0, err_pulse=0, err_count=0, timeout counter=0, re-arm flag set.
REQ-030 Reset in ACCESS aborts the transaction with no m_ready pulse and no error count.

Configuration
REQ-031 Macro IOMEM_TIMEOUT_EN defined: 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle; on reaching TIMEOUT_CYCLES without s_ready -> DONE with rdata 32'hFFFF_FFFF, err_pulse=1, s_valid dropped.
REQ-032 s_ready arriving in the same cycle as the timeout wins: normal completion, no error.
REQ-033 Macro undefined: no counter logic; ACCESS waits indefinitely for s_ready.

Structure
REQ-034 Package iomem_pkg holds the state enum, DEFAULT_BASE_PAGE, TIMEOUT_RDATA (32'hFFFF_FFFF), and UNMAPPED_RDATA (0).
REQ-035 Sub-module iomem_timeout (counter, clear, enable, expire output) is instantiated only under IOMEM_TIMEOUT_EN.

Verification
REQ-036 Read addr 0x0300_0004, slot 0 ready on the first s_valid cycle with data 0x1234_5678 -> s_valid=8'b0000_0001 for 1 cycle, m_ready 2 cycles after m_valid, m_rdata=0x1234_5678.
REQ-037 Write addr 0x0700_0000, wstrb 4'hF, data 0xA5A5_A5A5; slot 4 ready after 5 cycles -> s_wdata=0xA5A5_A5A5, s_valid[4] held 5 cycles, single m_ready pulse.
REQ-038 Access to 0x0200_0000 and to 0x0B00_0000 -> no s_valid, m_rdata=0, err_pulse each, err_count=2.
REQ-039 IOMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, slot 2 never ready -> m_ready after 16 ACCESS cycles, m_rdata=0xFFFF_FFFF, err_pulse=1; repeat with ready on cycle 16 -> normal data, no error.
REQ-040 resetn low mid-ACCESS -> all outputs 0 immediately, no m_ready; next request completes normally; 300 unmapped accesses -> err_count=255.
